// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped UART transmitter with TX FIFO (optional parity via UART_TX_PARITY_EN)
module uart_tx_mmio #(
  parameter int unsigned CLK_FREQ_HZ = 12_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic        mem_ready_o,
  output logic [31:0] mem_rdata_o,
  output logic        tx_o
);

  localparam int unsigned DIVISOR = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned DIV_W   = $clog2(DIVISOR);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state, state_d;
  logic [DIV_W-1:0]   baud_cnt;
  logic               baud_tick;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;
`ifdef UART_TX_PARITY_EN
  logic               par;
`endif

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full, empty, push, pop;
  logic [7:0]         fifo_rdata;

  logic               sel, req, is_data, is_status, data_wr, accept;
  logic [31:0]        status;
  logic               unused_bits;

  assign unused_bits = ^{mem_addr_i[1:0], mem_wdata_i[31:8]};

  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign fifo_rdata = mem[rd_ptr];
  assign baud_tick  = (baud_cnt == DIV_W'(DIVISOR - 1));

  // Bus decode; a full-FIFO DATA write may complete in the same cycle the serializer pops.
  assign sel       = (mem_addr_i[31:4] == BASE_ADDR[31:4]);
  assign req       = mem_valid_i && sel && !mem_ready_o;
  assign is_data   = (mem_addr_i[3:2] == 2'd0);
  assign is_status = (mem_addr_i[3:2] == 2'd1);
  assign data_wr   = is_data && mem_wstrb_i[0];
  assign accept    = req && !(data_wr && full && !pop);
  assign push      = accept && data_wr;

  // STATUS word assembled from registered FIFO/FSM state.
  always_comb begin
    status      = '0;
    status[0]   = full;
    status[1]   = empty;
    status[2]   = (state != IDLE);
    status[7:4] = 4'(count);
  end

  // Bus response: one-cycle ready pulse, read data only alongside it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_ready_o <= 1'b0;
      mem_rdata_o <= '0;
    end else begin
      mem_ready_o <= accept;
      mem_rdata_o <= (accept && is_status && (mem_wstrb_i == 4'b0000)) ? status : '0;
    end
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= mem_wdata_i[7:0];
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Serializer next-state and pop decision.
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: if (baud_tick) state_d = DATA;
      DATA: begin
        if (baud_tick && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_tick) state_d = STOP;
`endif
      STOP: begin
        if (baud_tick) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level decoded from the registered serializer state.
  always_comb begin
    tx_o = 1'b1;
    case (state)
      START:   tx_o = 1'b0;
      DATA:    tx_o = shreg[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_o = par;
`endif
      default: tx_o = 1'b1;
    endcase
  end

  // Serializer registers: state, baud counter, bit counter, shift register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state <= state_d;
      if (pop) begin
        shreg    <= fifo_rdata;
        baud_cnt <= '0;
        bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
        par      <= ^fifo_rdata;
`endif
      end else if (state != IDLE) begin
        if (baud_tick) begin
          baud_cnt <= '0;
          if (state == DATA) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end else begin
          baud_cnt <= baud_cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - directed self-checking bench for uart_tx_mmio
module tb_uart_tx_mmio;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11 * DIV;
`else
  localparam int FL = 10 * DIV;
`endif
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        ready;
  logic [31:0] rdata;
  logic        tx;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_bytes [16];

  always #5 clk = ~clk;

  uart_tx_mmio #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD_RATE  (100_000),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .mem_valid_i(valid),
    .mem_addr_i (addr),
    .mem_wdata_i(wdata),
    .mem_wstrb_i(wstrb),
    .mem_ready_o(ready),
    .mem_rdata_o(rdata),
    .tx_o       (tx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input bit hold, output logic [31:0] rd, output int lat);
    @(negedge clk);
    valid = 1'b1; addr = a; wdata = d; wstrb = s;
    lat = 0;
    while (lat < 2000) begin
      @(negedge clk);
      lat++;
      if (ready === 1'b1) break;
    end
    rd = rdata;
    if (hold) begin
      @(negedge clk);
      chk("ready_single_pulse", 32'(ready), 32'd0);
    end
    valid = 1'b0; wstrb = 4'b0000;
  endtask

  task automatic write_data(input logic [7:0] b, input int exp_lat, input string tag);
    logic [31:0] rd;
    int lat;
    bus(BASE, {24'hC0FFEE, b}, 4'b0001, 1'b0, rd, lat);
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic read_status(input logic [31:0] exp, input bit hold, input string tag);
    logic [31:0] rd;
    int lat;
    bus(BASE + 32'h4, 32'h0, 4'b0000, hold, rd, lat);
    chk(tag, rd, exp);
    chk({tag, "_lat"}, lat, 1);
  endtask

  function automatic logic cell_val(input logic [7:0] b, input int c);
    if (c == 0) return 1'b0;
    if (c <= 8) return b[c-1];
`ifdef UART_TX_PARITY_EN
    if (c == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Waits for the start bit, then checks every cycle of nfr frames and the idle line after.
  task automatic frames(input int nfr, input int exp_wait, input string tag);
    int w = 0;
    while (tx !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_start_wait"}, w, exp_wait);
    for (int t = 0; t < nfr * FL; t++) begin
      chk(tag, 32'(tx), 32'(cell_val(exp_bytes[t / FL], (t % FL) / DIV)));
      @(negedge clk);
    end
    for (int t = 0; t < 10; t++) begin
      chk({tag, "_idle"}, 32'(tx), 32'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int lat;
    int hits;

    // Reset
    repeat (5) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    read_status(32'h2, 1'b0, "rst_status");

    // Single byte 0x55, then a held-valid status read completes once
    exp_bytes[0] = 8'h55;
    write_data(8'h55, 1, "single_wr");
    frames(1, 1, "single");
    read_status(32'h2, 1'b1, "single_status");

    // Other registers and DATA read
    bus(BASE, 32'h0, 4'b0000, 1'b0, rd, lat);
    chk("data_read", rd, 32'h0);
    chk("data_read_lat", lat, 1);
    bus(BASE + 32'hC, 32'hFFFF_FFFF, 4'b1111, 1'b0, rd, lat);
    chk("reg_c_write_lat", lat, 1);
    bus(BASE + 32'h8, 32'h0, 4'b0000, 1'b0, rd, lat);
    chk("reg_8_read", rd, 32'h0);
    read_status(32'h2, 1'b0, "reg_c_no_push");

    // Backpressure: ten writes, the tenth stalls until the second pop
    for (int i = 0; i < 10; i++) exp_bytes[i] = 8'(i);
    fork
      begin
        for (int i = 0; i < 9; i++) write_data(8'(i), 1, "bp_wr");
        write_data(8'h09, FL - 16, "bp_stall");
        read_status(32'h85, 1'b0, "bp_status_full");
      end
      frames(10, 3, "bp_frames");
    join
    read_status(32'h2, 1'b0, "bp_status_end");

    // Decode: out-of-range address never completes
    @(negedge clk);
    valid = 1'b1; addr = BASE + 32'h10; wstrb = 4'b0000;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready === 1'b1) hits++;
    end
    chk("decode_ready_hits", hits, 0);
    valid = 1'b0;
    bus(BASE, 32'h0000_0077, 4'b0010, 1'b0, rd, lat);
    chk("wstrb_no_push_lat", lat, 1);
    read_status(32'h2, 1'b0, "wstrb_no_push_status");

    // Reset mid-frame with three bytes queued
    write_data(8'hA1, 1, "mid_wr0");
    write_data(8'h3C, 1, "mid_wr1");
    write_data(8'hFF, 1, "mid_wr2");
    repeat (32) @(negedge clk);
    chk("mid_pre_reset_tx", 32'(tx), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_tx", 32'(tx), 32'd1);
    chk("mid_reset_ready", 32'(ready), 32'd0);
    rst_n = 1'b1;
    read_status(32'h2, 1'b0, "mid_status");
    hits = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) hits++;
    end
    chk("mid_no_frames", hits, 0);

`ifdef UART_TX_PARITY_EN
    // Parity: 0x07 has odd weight, 0x55 even
    exp_bytes[0] = 8'h07;
    write_data(8'h07, 1, "par07_wr");
    frames(1, 1, "par07");
    exp_bytes[0] = 8'h55;
    write_data(8'h55, 1, "par55_wr");
    frames(1, 1, "par55");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
